// File: rtl/mac_acc_negator_pipe.sv
// mac_acc_negator_pipe: two-stage conditional two's-complement negator for
// NUM_LANES accumulator lanes, grouped into 2^mode-lane words.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              clock enable, 0 freezes all state
//   in_valid/ready  input handshake; in_mode, in_signed, in_data, in_neg
//   out_valid/ready output handshake; out_data, out_ovf (per group MSB lane)
module mac_acc_negator_pipe #(
    parameter int LANE_WIDTH = 32,
    parameter int NUM_LANES  = 4,
    parameter int MODE_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [MODE_WIDTH-1:0]            in_mode,
    input  logic                             in_signed,
    input  logic [NUM_LANES*LANE_WIDTH-1:0]  in_data,
    input  logic [NUM_LANES-1:0]             in_neg,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_LANES*LANE_WIDTH-1:0]  out_data,
    output logic [NUM_LANES-1:0]             out_ovf
);

    localparam int LW    = LANE_WIDTH;
    localparam int N     = NUM_LANES;
    localparam int NP1   = NUM_LANES + 1;
    localparam int DW    = NUM_LANES * LANE_WIDTH;
    localparam int LOG2N = $clog2(NUM_LANES);
    localparam logic [LW-1:0] TOP_BIT = {1'b1, {(LW-1){1'b0}}};

    // log2 of the group size, clamped so a group never exceeds all lanes
    function automatic int grp_log(input logic [MODE_WIDTH-1:0] m);
        int ml;
        ml = int'(m);
        return (ml > LOG2N) ? LOG2N : ml;
    endfunction

    // pipeline state
    logic                  s1_valid;
    logic [DW-1:0]         s1_inv;
    logic [N-1:0]          s1_ones;
    logic [N-1:0]          s1_neg;
    logic [N-1:0]          s1_msb;
    logic [MODE_WIDTH-1:0] s1_mode;
    logic                  s2_valid;

    // next-state terms
    logic [DW-1:0]         inv_d;
    logic [N-1:0]          ones_d;
    logic [N-1:0]          neg_d;
    logic [N-1:0]          msb_d;
    logic [DW-1:0]         data_d;
    logic [N-1:0]          ovf_d;

    logic s1_adv;
    logic s2_adv;

    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = en & s1_adv;
    assign out_valid = s2_valid;

    // Stage 1: decide negation per group, invert, and precompute the
    // per-lane carry-propagate flag and the group most-negative flag.
    always_comb begin
        int gl;
        int g;
        int base;
        int top;
        logic [LW-1:0] lane;
        logic [LW-1:0] inv;
        logic [N-1:0]  lz;
        logic [N-1:0]  lt;
        logic [N-1:0]  grp_mask;
        logic [N-1:0]  top_mask;
        logic          nk;
        logic          mk;
        inv_d  = '0;
        ones_d = '0;
        neg_d  = '0;
        msb_d  = '0;
        lz     = '0;
        lt     = '0;
        gl     = grp_log(in_mode);
        g      = 1 << gl;
        for (int k = 0; k < N; k++) begin
            lane = LW'(in_data >> (k * LW));
            lz   = lz | (N'(lane == '0) << k);
            lt   = lt | (N'(lane == TOP_BIT) << k);
        end
        for (int k = 0; k < N; k++) begin
            base     = (k >> gl) << gl;
            top      = base + g - 1;
            grp_mask = N'((NP1'(1) << g) - NP1'(1)) << base;
            top_mask = N'(1) << top;
            nk       = in_signed & (|(in_neg & top_mask));
            lane     = LW'(in_data >> (k * LW));
            inv      = nk ? ~lane : lane;
            // most-negative: top lane is MSB-only, every lower lane is zero
            mk       = (|(lt & top_mask))
                     & ~(|(~lz & grp_mask & ~top_mask));
            inv_d    = inv_d | (DW'(inv) << (k * LW));
            ones_d   = ones_d | (N'(&inv) << k);
            neg_d    = neg_d | (N'(nk) << k);
            msb_d    = msb_d | (N'(mk) << k);
        end
    end

    // Stage 2: ripple the +1 through each group; the carry restarts at
    // every group's lowest lane.
    always_comb begin
        int   gl;
        int   g;
        int   base;
        int   top;
        logic nk;
        logic ok;
        logic mk;
        logic c;
        logic cout;
        logic [LW-1:0] sum;
        data_d = '0;
        ovf_d  = '0;
        cout   = 1'b0;
        gl     = grp_log(s1_mode);
        g      = 1 << gl;
        for (int k = 0; k < N; k++) begin
            base   = (k >> gl) << gl;
            top    = base + g - 1;
            nk     = |(s1_neg & (N'(1) << k));
            ok     = |(s1_ones & (N'(1) << k));
            mk     = |(s1_msb & (N'(1) << k));
            c      = (base == k) ? nk : cout;
            sum    = LW'(s1_inv >> (k * LW)) + LW'(c);
            cout   = c & ok;
            data_d = data_d | (DW'(sum) << (k * LW));
            ovf_d  = ovf_d | (N'(nk & mk & (top == k)) << k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_inv   <= '0;
            s1_ones  <= '0;
            s1_neg   <= '0;
            s1_msb   <= '0;
            s1_mode  <= '0;
            s2_valid <= 1'b0;
            out_data <= '0;
            out_ovf  <= '0;
        end else if (en) begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= data_d;
                    out_ovf  <= ovf_d;
                end
            end
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_inv  <= inv_d;
                    s1_ones <= ones_d;
                    s1_neg  <= neg_d;
                    s1_msb  <= msb_d;
                    s1_mode <= in_mode;
                end
            end
        end
    end

endmodule
